// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the memory-port arbiter, the IF/MEM requesters and the SRAM-like bus.
// The slave view is the arbiter; the master view is everything around it.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        stallreq_for_inst;
  logic        stallreq_for_data;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wen, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
    output stallreq_for_inst, stallreq_for_data
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wen, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wen, mem_addr, mem_wdata,
    input  stallreq_for_inst, stallreq_for_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store, one transaction
// at a time, with data priority bounded by a starvation limit on pending fetches.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input logic          clk,
  input logic          rst,
  mem_port_arbiter_if.slave port
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic       OWN_INST   = 1'b0;
  localparam logic       OWN_DATA   = 1'b1;
  localparam logic [1:0] STREAK_MAX = 2'(STARVE_LIMIT);

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v < STREAK_MAX) ? v + 2'd1 : STREAK_MAX;
  endfunction

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [1:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic        inst_cpl_q, inst_cpl_d;
  logic        data_cpl_q, data_cpl_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic grant_inst, grant_data, grant_any;
  logic bus_done;
  logic inst_busy, data_busy;

  // Grants are only issued from IDLE; a reset cycle never grants.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!rst && state_q == S_IDLE) begin
      if (port.data_req && (!port.inst_req || streak_q < STREAK_MAX)) begin
        grant_data = 1'b1;
      end else if (port.inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  assign grant_any = grant_inst | grant_data;
  assign bus_done  = (state_q == S_DATA) && port.mem_data_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_any)        state_d = S_ADDR;
      S_ADDR:  if (port.mem_addr_ok) state_d = S_DATA;
      S_DATA:  if (port.mem_data_ok) state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    port.mem_req   = 1'b0;
    port.mem_wr    = 1'b0;
    port.mem_wen   = 4'd0;
    port.mem_addr  = 32'd0;
    port.mem_wdata = 32'd0;
    if (state_q == S_ADDR) begin
      port.mem_req   = 1'b1;
      port.mem_wr    = wr_q;
      port.mem_wen   = wen_q;
      port.mem_addr  = addr_q;
      port.mem_wdata = wdata_q;
    end
  end

  assign port.inst_addr_ok = grant_inst;
  assign port.data_addr_ok = grant_data;
  assign port.inst_data_ok = inst_cpl_q;
  assign port.data_data_ok = data_cpl_q;
  assign port.inst_rdata   = inst_rdata_q;
  assign port.data_rdata   = data_rdata_q;

  // Request capture: only stores carry byte enables and write data onto the bus.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    if (grant_data) begin
      owner_d = OWN_DATA;
      addr_d  = port.data_addr;
      wr_d    = port.data_wr;
      wen_d   = port.data_wr ? port.data_wen   : 4'd0;
      wdata_d = port.data_wr ? port.data_wdata : 32'd0;
    end else if (grant_inst) begin
      owner_d = OWN_INST;
      addr_d  = port.inst_addr;
      wr_d    = 1'b0;
      wen_d   = 4'd0;
      wdata_d = 32'd0;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (grant_data) begin
      streak_d = port.inst_req ? sat_inc(streak_q) : 2'd0;
    end else if (grant_inst) begin
      streak_d = 2'd0;
    end
  end

  // Completion is reported one cycle after the bus ack; stores keep the last read word.
  always_comb begin
    inst_cpl_d   = bus_done && (owner_q == OWN_INST);
    data_cpl_d   = bus_done && (owner_q == OWN_DATA);
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (bus_done && !wr_q) begin
      if (owner_q == OWN_INST) begin
        inst_rdata_d = port.mem_rdata;
      end else begin
        data_rdata_d = port.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_INST;
      streak_q     <= 2'd0;
      inst_cpl_q   <= 1'b0;
      data_cpl_q   <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      inst_cpl_q   <= inst_cpl_d;
      data_cpl_q   <= data_cpl_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wr_q    <= wr_d;
    wen_q   <= wen_d;
    wdata_q <= wdata_d;
  end

  // The owner stays busy through the ack cycle, so the pending-completion window is covered
  // and the stall drops exactly when X_data_ok pulses.
  assign inst_busy = (state_q != S_IDLE) && (owner_q == OWN_INST);
  assign data_busy = (state_q != S_IDLE) && (owner_q == OWN_DATA);

  assign port.stallreq_for_inst = (port.inst_req & ~grant_inst) | grant_inst | inst_busy;
  assign port.stallreq_for_data = (port.data_req & ~grant_data) | grant_data | data_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic for mem_port_arbiter, scored against a
// transaction-level model of grants, bus transfers, completions and stalls.
module tb_mem_port_arbiter;
  localparam int LIM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if ifc();

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (ifc.slave)
  );

  typedef struct packed {
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct packed {
    logic        own_data;
    logic        wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  logic [31:0] mem_model [logic [31:0]];
  bit          rst_drive = 1'b1;
  bit          i_gnt = 1'b0, d_gnt = 1'b0;

  int   cfg_aw = 0, cfg_dw = 0;
  bit   cfg_rand = 1'b0;
  int   resp_phase = 0, acnt = 0, dcnt = 0;
  txn_t rcur;

  int          m_phase = 0;
  int          m_streak = 0;
  txn_t        m_cur = '0;
  bit          m_cpl_pend = 1'b0, m_cpl_own = 1'b0, m_cpl_load = 1'b0;
  logic [31:0] m_cpl_val = '0;
  logic [31:0] exp_irdata = '0, exp_drdata = '0;

  int g_log[$];
  int n_idok = 0, n_ddok = 0, n_mreq = 0, n_stall_d = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    mem_model[a] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus slave: fixed or random ack delays, per-address memory contents.
  initial begin : bus_resp
    ifc.mem_addr_ok = 1'b0;
    ifc.mem_data_ok = 1'b0;
    ifc.mem_rdata   = 32'd0;
    forever begin
      @(posedge clk); #1;
      ifc.mem_addr_ok = 1'b0;
      ifc.mem_data_ok = 1'b0;
      ifc.mem_rdata   = $urandom;
      if (resp_phase == 1 && ifc.mem_req !== 1'b1) resp_phase = 0;
      if (resp_phase == 2) begin
        if (dcnt == 0) begin
          ifc.mem_data_ok = 1'b1;
          if (rcur.wr) mem_write(rcur.addr, rcur.wen, rcur.wdata);
          else         ifc.mem_rdata = mem_rd(rcur.addr);
          resp_phase = 0;
        end else dcnt--;
      end else if (ifc.mem_req === 1'b1) begin
        if (resp_phase == 0) begin
          acnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_aw;
          resp_phase = 1;
        end
        if (acnt == 0) begin
          ifc.mem_addr_ok = 1'b1;
          rcur.addr  = ifc.mem_addr;
          rcur.wr    = ifc.mem_wr;
          rcur.wen   = ifc.mem_wen;
          rcur.wdata = ifc.mem_wdata;
          dcnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_dw;
          resp_phase = 2;
        end else acnt--;
      end
    end
  end

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_cpl_pend = 1'b0;
    exp_irdata = '0; exp_drdata = '0;
  endtask

  task automatic model_check();
    bit   idle, gd, gi;
    txn_t z;
    z    = '0;
    idle = (m_phase == 0);
    gd   = idle && ifc.data_req && (!ifc.inst_req || m_streak < LIM);
    gi   = idle && ifc.inst_req && !gd;
    chk("inst_addr_ok", ifc.inst_addr_ok, gi);
    chk("data_addr_ok", ifc.data_addr_ok, gd);
    chk("inst_data_ok", ifc.inst_data_ok, m_cpl_pend && !m_cpl_own);
    chk("data_data_ok", ifc.data_data_ok, m_cpl_pend && m_cpl_own);
    if (m_cpl_pend && m_cpl_load) begin
      if (m_cpl_own) exp_drdata = m_cpl_val;
      else           exp_irdata = m_cpl_val;
    end
    chk("inst_rdata", ifc.inst_rdata, exp_irdata);
    chk("data_rdata", ifc.data_rdata, exp_drdata);
    if (m_phase == 1) z = m_cur;
    chk("mem_req",   ifc.mem_req,   m_phase == 1);
    chk("mem_addr",  ifc.mem_addr,  z.addr);
    chk("mem_wr",    ifc.mem_wr,    z.wr);
    chk("mem_wen",   ifc.mem_wen,   z.wen);
    chk("mem_wdata", ifc.mem_wdata, z.wdata);
    chk("stall_inst", ifc.stallreq_for_inst, ifc.inst_req || (m_phase != 0 && !m_cur.own_data));
    chk("stall_data", ifc.stallreq_for_data, ifc.data_req || (m_phase != 0 &&  m_cur.own_data));

    i_gnt = ifc.inst_addr_ok;
    d_gnt = ifc.data_addr_ok;
    if (ifc.data_addr_ok) g_log.push_back(1);
    if (ifc.inst_addr_ok) g_log.push_back(0);
    if (ifc.inst_data_ok)      n_idok++;
    if (ifc.data_data_ok)      n_ddok++;
    if (ifc.mem_req)           n_mreq++;
    if (ifc.stallreq_for_data) n_stall_d++;

    m_cpl_pend = 1'b0;
    if (m_phase == 1 && ifc.mem_addr_ok) begin
      m_phase = 2;
    end else if (m_phase == 2 && ifc.mem_data_ok) begin
      m_phase = 0; m_cpl_pend = 1'b1;
      m_cpl_own = m_cur.own_data; m_cpl_load = !m_cur.wr; m_cpl_val = mem_rd(m_cur.addr);
    end else if (gd) begin
      m_cur.own_data = 1'b1;
      m_cur.addr  = ifc.data_addr;
      m_cur.wr    = ifc.data_wr;
      m_cur.wen   = ifc.data_wr ? ifc.data_wen   : 4'd0;
      m_cur.wdata = ifc.data_wr ? ifc.data_wdata : 32'd0;
      m_phase  = 1;
      m_streak = ifc.inst_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
    end else if (gi) begin
      m_cur = '0;
      m_cur.addr = ifc.inst_addr;
      m_phase  = 1;
      m_streak = 0;
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
    rst = rst_drive;
    if (rst_drive) begin
      ifc.inst_req = 1'b0; ifc.data_req = 1'b0;
    end else begin
      if (ifc.inst_req && i_gnt) ifc.inst_req = 1'b0;
      if (!ifc.inst_req && iq.size() > 0) begin
        ifc.inst_req = 1'b1; ifc.inst_addr = iq.pop_front();
      end
      if (ifc.data_req && d_gnt) ifc.data_req = 1'b0;
      if (!ifc.data_req && dq.size() > 0) begin
        dreq_t d;
        d = dq.pop_front();
        ifc.data_req = 1'b1; ifc.data_wr = d.wr; ifc.data_wen = d.wen;
        ifc.data_addr = d.addr; ifc.data_wdata = d.wdata;
      end
    end
    i_gnt = 1'b0; d_gnt = 1'b0;
    @(negedge clk);
    if (rst) model_reset();
    else     model_check();
  endtask

  task automatic push_data(input logic wr, input logic [3:0] wen, input logic [31:0] a,
                           input logic [31:0] wd);
    dreq_t d;
    d.wr = wr; d.wen = wen; d.addr = a; d.wdata = wd;
    dq.push_back(d);
  endtask

  function automatic bit busy();
    return iq.size() > 0 || dq.size() > 0 || ifc.inst_req || ifc.data_req ||
           m_phase != 0 || m_cpl_pend || resp_phase != 0;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy() && n < 400) begin step(); n++; end
    chk({tag, "_drain_timeout"}, busy(), 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int ord[6];
    int n;
    ord = '{1, 1, 0, 1, 1, 0};
    ifc.inst_req = 1'b0; ifc.inst_addr = '0;
    ifc.data_req = 1'b0; ifc.data_wr = 1'b0; ifc.data_wen = '0;
    ifc.data_addr = '0;  ifc.data_wdata = '0;

    rst_drive = 1'b1; step(); step(); rst_drive = 1'b0;
    step();
    chk("rst_inst_rdata", ifc.inst_rdata, 32'd0);
    chk("rst_data_rdata", ifc.data_rdata, 32'd0);
    chk("rst_mem_req", ifc.mem_req, 1'b0);
    chk("rst_stall_inst", ifc.stallreq_for_inst, 1'b0);

    // Single load with immediate bus acks.
    mem_model[32'h100] = 32'hDEADBEEF;
    push_data(1'b0, 4'hF, 32'h100, 32'hFFFF_FFFF);
    step();
    chk("ld_c0_addr_ok", ifc.data_addr_ok, 1'b1);
    chk("ld_c0_stall", ifc.stallreq_for_data, 1'b1);
    step();
    chk("ld_c1_mem_req", ifc.mem_req, 1'b1);
    chk("ld_c1_mem_addr", ifc.mem_addr, 32'h100);
    chk("ld_c1_mem_wen", ifc.mem_wen, 4'd0);
    step();
    chk("ld_c2_stall", ifc.stallreq_for_data, 1'b1);
    chk("ld_c2_data_ok", ifc.data_data_ok, 1'b0);
    step();
    chk("ld_c3_data_ok", ifc.data_data_ok, 1'b1);
    chk("ld_c3_rdata", ifc.data_rdata, 32'hDEADBEEF);
    chk("ld_c3_stall", ifc.stallreq_for_data, 1'b0);

    // Store: bus carries write fields, read data register untouched.
    push_data(1'b1, 4'b0011, 32'h200, 32'h0000_1234);
    step(); step();
    chk("st_mem_wr", ifc.mem_wr, 1'b1);
    chk("st_mem_wen", ifc.mem_wen, 4'b0011);
    chk("st_mem_wdata", ifc.mem_wdata, 32'h0000_1234);
    step(); step();
    chk("st_data_ok", ifc.data_data_ok, 1'b1);
    chk("st_rdata_kept", ifc.data_rdata, 32'hDEADBEEF);

    // Contention: both requesters always pending.
    g_log.delete();
    for (int i = 0; i < 3; i++) iq.push_back(32'h0040_0010 + 32'(i * 4));
    for (int i = 0; i < 6; i++) push_data(1'b0, 4'h0, 32'h0000_0300 + 32'(i * 4), 32'd0);
    drain("contend");
    chk("contend_grants", g_log.size(), 9);
    for (int i = 0; i < 6; i++) chk($sformatf("contend_order_%0d", i), g_log[i], ord[i]);

    // Backpressure: 4 withheld address cycles, 3 withheld data cycles.
    cfg_aw = 4; cfg_dw = 3;
    n_mreq = 0; n_ddok = 0; n_stall_d = 0; n_idok = 0;
    push_data(1'b0, 4'h0, 32'h180, 32'd0);
    drain("bp");
    chk("bp_mem_req_cycles", n_mreq, 5);
    chk("bp_data_ok_once", n_ddok, 1);
    chk("bp_stall_cycles", n_stall_d, 10);
    chk("bp_no_inst_ok", n_idok, 0);

    // Reset while in DATA; the late bus ack must be ignored.
    cfg_aw = 0; cfg_dw = 6; n_idok = 0;
    iq.push_back(32'h0000_0500);
    step(); step(); step();
    chk("rstdata_in_data", m_phase, 2);
    rst_drive = 1'b1; step(); rst_drive = 1'b0;
    step();
    chk("rstdata_inst_rdata", ifc.inst_rdata, 32'd0);
    chk("rstdata_data_rdata", ifc.data_rdata, 32'd0);
    chk("rstdata_mem_req", ifc.mem_req, 1'b0);
    chk("rstdata_mem_addr", ifc.mem_addr, 32'd0);
    chk("rstdata_stall_inst", ifc.stallreq_for_inst, 1'b0);
    chk("rstdata_inst_data_ok", ifc.inst_data_ok, 1'b0);
    n = 0;
    while (resp_phase != 0 && n < 20) begin step(); n++; end
    step();
    chk("rstdata_stale_seen", resp_phase, 0);
    chk("rstdata_no_cpl", n_idok, 0);
    cfg_dw = 0;
    iq.push_back(32'h0000_0504);
    drain("rstdata_fresh");
    chk("rstdata_fresh_cpl", n_idok, 1);
    chk("rstdata_fresh_rdata", ifc.inst_rdata, mem_rd(32'h0000_0504));

    // Fetch only.
    n_stall_d = 0;
    iq.push_back(32'h0040_0000);
    step();
    chk("if_c0_addr_ok", ifc.inst_addr_ok, 1'b1);
    step(); step(); step();
    chk("if_c3_data_ok", ifc.inst_data_ok, 1'b1);
    chk("if_c3_rdata", ifc.inst_rdata, mem_rd(32'h0040_0000));
    chk("if_no_data_stall", n_stall_d, 0);

    // Randomized mixed traffic with random bus delays.
    cfg_rand = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (iq.size() == 0 && $urandom_range(0, 2) == 0)
        iq.push_back(32'h0000_1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00});
      if (dq.size() == 0 && $urandom_range(0, 2) == 0)
        push_data(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  32'h0000_1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
      step();
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
